fifo_wr_arb: RTL

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

---
 rtl/fifo_arb_pkg.sv | 15 +
 rtl/rr_pick.sv | 33 +++
 rtl/fifo_wr_arb.sv | 120 ++++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared defaults and types for the FIFO write arbiter.
package fifo_arb_pkg;

  localparam int NUM_REQ_DEF   = 4;
  localparam int DATA_W_DEF    = 4;
  localparam int BURST_MAX_DEF = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  typedef logic [3:0] beat_cnt_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req at or after start, wrapping.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [IW:0]   sum;
  logic [IW-1:0] cand;

  always_comb begin
    // NOTE: every output and temporary gets a default before the loop so no latch is inferred.
    found = 1'b0;
    idx   = '0;
    sum   = '0;
    cand  = '0;
    // Walk offsets from farthest to nearest so the nearest hit overwrites the others.
    for (int i = N - 1; i >= 0; i--) begin
      sum = {1'b0, start} + (IW + 1)'(i);
      if (sum >= (IW + 1)'(N)) sum = sum - (IW + 1)'(N);
      cand = sum[IW-1:0];
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin burst arbiter feeding one downstream FIFO write port.
// Define FIFO_ARB_STATS_EN to add saturating per-requester beat counters on stat_beats.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BURST_MAX = BURST_MAX_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         fifo_full,
  output logic                         write_en,
  output logic [DATA_W-1:0]            write_data,
`ifdef FIFO_ARB_STATS_EN
  output logic [NUM_REQ*8-1:0]         stat_beats,
`endif
  output logic                         grant_valid,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id
);

  localparam int        ID_W       = $clog2(NUM_REQ);
  localparam beat_cnt_t BURST_LAST = beat_cnt_t'(BURST_MAX);

  arb_state_t        state;
  logic [ID_W-1:0]   rr_ptr;
  beat_cnt_t         beat_cnt;
  beat_cnt_t         beat_next;
  logic [ID_W-1:0]   next_ptr;
  logic              pick_found;
  logic [ID_W-1:0]   pick_idx;
  logic              owner_valid;
  logic              beat;
  logic [DATA_W-1:0] req_slice [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign req_slice[g] = req_data[g*DATA_W +: DATA_W];
  end

  rr_pick #(.N(NUM_REQ), .IW(ID_W)) u_pick (
    .req   (req_valid),
    .start (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // rst gates the beat so a reset cycle never writes, even mid-burst.
  assign owner_valid = req_valid[grant_id];
  assign beat        = grant_valid & owner_valid & ~fifo_full & ~rst;
  assign beat_next   = beat_cnt + beat_cnt_t'(1);
  assign next_ptr    = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);

  always_comb begin
    req_ready  = '0;
    write_en   = beat;
    write_data = '0;
    if (beat) begin
      req_ready[grant_id] = 1'b1;
      write_data          = req_slice[grant_id];
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      beat_cnt    <= '0;
      grant_id    <= '0;
      grant_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            state       <= GRANT;
            grant_id    <= pick_idx;
            grant_valid <= 1'b1;
            beat_cnt    <= '0;
          end
        end
        GRANT: begin
          // A dropped request ends the grant even while the FIFO is full.
          if (!owner_valid || (beat && beat_next == BURST_LAST)) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            beat_cnt    <= '0;
            rr_ptr      <= next_ptr;
          end else if (beat) begin
            beat_cnt <= beat_next;
          end
        end
        default: begin
          state       <= IDLE;
          grant_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [7:0] stat_cnt [NUM_REQ];

  always_ff @(posedge clk) begin
    // NOTE: these counters are a handful of flops, not a RAM, so a reset loop over them is fine.
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) stat_cnt[i] <= '0;
    end else if (beat && stat_cnt[grant_id] != 8'hFF) begin
      stat_cnt[grant_id] <= stat_cnt[grant_id] + 8'd1;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    assign stat_beats[g*8 +: 8] = stat_cnt[g];
  end
`endif

endmodule
